gba_dsound_mixer_n: RTL and testbench

Parametrised N-channel direct-sound engine with a time-multiplexed stereo mixer, the successor to the fixed two-channel direct-sound/ds_mixer pair in the GBA audio path. Each channel unpacks 32-bit FIFO words into samples on a selectable timer overflow and raises DMA refill requests at a configurable level. On each output strobe, a sequencer accumulates the PSG pre-mix and all enabled channels into a saturated stereo sample. The block sits between the FIFO/timer/DMA logic and the audio output, in the `gba_clk` domain.

---
 rtl/gba_dsound_mixer_n.sv | 183 ++++++++++++++++++
 tb/tb_gba_dsound_mixer_n.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gba_dsound_mixer_n.sv
// gba_dsound_mixer_n: N-channel direct-sound engine. Each channel unpacks 32-bit
// FIFO words into signed samples on its selected timer overflow and asks DMA for
// refills. On each sample_tick a sequencer mixes the PSG pre-mix and every
// enabled channel, one channel per cycle, into a saturated stereo sample.
module gba_dsound_mixer_n #(
  parameter int NUM_CH     = 2,
  parameter int NUM_TIMERS = 2,
  parameter int TSEL_W     = $clog2(NUM_TIMERS),
  parameter int SAMPLE_W   = 8,
  parameter int FIFO_LVL_W = 4,
  parameter int REQ_LEVEL  = 4,
  parameter int OUT_W      = 24
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_TIMERS-1:0]        timer_ovf,
  input  logic [NUM_CH*FIFO_LVL_W-1:0] fifo_size,
  input  logic [NUM_CH*32-1:0]         fifo_val,
  output logic [NUM_CH-1:0]            fifo_re,
  output logic [NUM_CH-1:0]            fifo_clr,
  input  logic [NUM_CH*TSEL_W-1:0]     ch_timer_sel,
  input  logic [NUM_CH-1:0]            ch_full_vol,
  input  logic [NUM_CH-1:0]            ch_en_l,
  input  logic [NUM_CH-1:0]            ch_en_r,
  input  logic [NUM_CH-1:0]            ch_reset,
  input  logic signed [15:0]           psg_l,
  input  logic signed [15:0]           psg_r,
  input  logic [1:0]                   psg_vol,
  input  logic                         sample_tick,
  output logic [NUM_CH-1:0]            sound_req,
  output logic signed [OUT_W-1:0]      out_l,
  output logic signed [OUT_W-1:0]      out_r,
  output logic                         out_valid,
  output logic                         overrun
);

  localparam int SPW   = 32 / SAMPLE_W;
  localparam int IDX_W = $clog2(SPW + 1);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Four guard bits above the larger of OUT_W and 20, so the full 16-bit PSG
  // term plus eight doubled 16-bit channels never wraps before saturation.
  localparam int ACC_W = ((OUT_W > 20) ? OUT_W : 20) + 4;

  localparam logic [IDX_W-1:0]        IDX_EMPTY = IDX_W'(SPW);
  localparam logic signed [ACC_W-1:0] SAT_HI    = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_LO    = ~SAT_HI;

  typedef enum logic [2:0] {S_IDLE, S_PSG, S_CH, S_SAT, S_OUT} mix_state_e;

  logic [31:0]                word_q [NUM_CH];
  logic [IDX_W-1:0]           idx_q  [NUM_CH];
  logic signed [SAMPLE_W-1:0] cur_q  [NUM_CH];

  logic [NUM_CH-1:0] ch_tick, ch_pop, ch_under, ch_low;

  mix_state_e              state_q, state_d;
  logic [CH_W-1:0]         ch_q;
  logic signed [ACC_W-1:0] acc_l_q, acc_r_q;
  logic signed [ACC_W-1:0] psg_term_l, psg_term_r, ch_term;
  logic [1:0]              psg_shift;

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_HI)      return OUT_W'(SAT_HI);
    else if (a < SAT_LO) return OUT_W'(SAT_LO);
    else                 return a[OUT_W-1:0];
  endfunction

  // Per-channel tick decode: which channels advance, pop, underrun or run low.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on every path,
    // so no latch can be inferred.
    for (int c = 0; c < NUM_CH; c++) begin
      ch_tick[c]  = timer_ovf[ch_timer_sel[c*TSEL_W +: TSEL_W]] & ~ch_reset[c];
      ch_pop[c]   = ch_tick[c] && (idx_q[c] == IDX_EMPTY)
                    && (fifo_size[c*FIFO_LVL_W +: FIFO_LVL_W] != '0);
      ch_under[c] = ch_tick[c] && (idx_q[c] == IDX_EMPTY)
                    && (fifo_size[c*FIFO_LVL_W +: FIFO_LVL_W] == '0);
      ch_low[c]   = (int'(fifo_size[c*FIFO_LVL_W +: FIFO_LVL_W]) - 1) <= REQ_LEVEL;
    end
  end

  assign fifo_re  = ch_pop   & {NUM_CH{reset_n}};
  assign fifo_clr = ch_reset & {NUM_CH{reset_n}};

  // Word register: loaded on a pop, zeroed by ch_reset.
  always_ff @(posedge clock) begin
    // NOTE: word_q has no reset; index at SPW guarantees a fresh word is
    // popped before any of its bits are read.
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_reset[c])    word_q[c] <= '0;
      else if (ch_pop[c]) word_q[c] <= fifo_val[c*32 +: 32];
    end
  end

  // Sample index, current sample and DMA request per channel.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      sound_req <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        idx_q[c] <= IDX_EMPTY;
        cur_q[c] <= '0;
      end
    end else begin
      sound_req <= (ch_pop & ch_low) | ch_under;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_reset[c]) begin
          idx_q[c] <= IDX_EMPTY;
          cur_q[c] <= '0;
        end else if (ch_tick[c] && (idx_q[c] != IDX_EMPTY)) begin
          cur_q[c] <= word_q[c][idx_q[c]*SAMPLE_W +: SAMPLE_W];
          idx_q[c] <= idx_q[c] + IDX_W'(1);
        end else if (ch_pop[c]) begin
          cur_q[c] <= fifo_val[c*32 +: SAMPLE_W];
          idx_q[c] <= IDX_W'(1);
        end
      end
    end
  end

  // Mixer state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Mixer next-state: PSG, one cycle per channel, saturate, output.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (sample_tick) state_d = S_PSG;
      S_PSG:   state_d = S_CH;
      S_CH:    if (ch_q == CH_W'(NUM_CH - 1)) state_d = S_SAT;
      S_SAT:   state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Scaled PSG terms and the term of the channel currently being summed.
  always_comb begin
    psg_shift  = psg_vol[1] ? 2'd0 : (psg_vol[0] ? 2'd1 : 2'd2);
    psg_term_l = ACC_W'(psg_l) >>> psg_shift;
    psg_term_r = ACC_W'(psg_r) >>> psg_shift;
    ch_term    = ACC_W'(cur_q[ch_q]) <<< ch_full_vol[ch_q];
  end

  // Mixer datapath: accumulate, saturate into the outputs, flag overruns.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      ch_q      <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_tick && (state_q != S_IDLE)) overrun <= 1'b1;
      case (state_q)
        S_PSG: begin
          acc_l_q <= psg_term_l;
          acc_r_q <= psg_term_r;
          ch_q    <= '0;
        end
        S_CH: begin
          if (ch_en_l[ch_q]) acc_l_q <= acc_l_q + ch_term;
          if (ch_en_r[ch_q]) acc_r_q <= acc_r_q + ch_term;
          if (ch_q != CH_W'(NUM_CH - 1)) ch_q <= ch_q + CH_W'(1);
        end
        S_SAT: begin
          out_l     <= saturate(acc_l_q);
          out_r     <= saturate(acc_r_q);
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_dsound_mixer_n.sv
// Testbench for gba_dsound_mixer_n: bench-owned FIFO queues, a sample-level
// channel model and an integer mix model, driven by directed and random steps.
module tb_gba_dsound_mixer_n;

  localparam int NUM_CH     = 2;
  localparam int NUM_TIMERS = 2;
  localparam int TSEL_W     = $clog2(NUM_TIMERS);
  localparam int SAMPLE_W   = 8;
  localparam int FIFO_LVL_W = 4;
  localparam int REQ_LEVEL  = 4;
  localparam int OUT_W      = 16;

  logic                         clock;
  logic                         reset_n;
  logic [NUM_TIMERS-1:0]        timer_ovf;
  logic [NUM_CH*FIFO_LVL_W-1:0] fifo_size;
  logic [NUM_CH*32-1:0]         fifo_val;
  logic [NUM_CH-1:0]            fifo_re, fifo_clr;
  logic [NUM_CH*TSEL_W-1:0]     ch_timer_sel;
  logic [NUM_CH-1:0]            ch_full_vol, ch_en_l, ch_en_r, ch_reset;
  logic signed [15:0]           psg_l, psg_r;
  logic [1:0]                   psg_vol;
  logic                         sample_tick;
  logic [NUM_CH-1:0]            sound_req;
  logic signed [OUT_W-1:0]      out_l, out_r;
  logic                         out_valid, overrun;

  gba_dsound_mixer_n #(
    .NUM_CH(NUM_CH), .NUM_TIMERS(NUM_TIMERS), .SAMPLE_W(SAMPLE_W),
    .FIFO_LVL_W(FIFO_LVL_W), .REQ_LEVEL(REQ_LEVEL), .OUT_W(OUT_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .timer_ovf(timer_ovf),
    .fifo_size(fifo_size), .fifo_val(fifo_val), .fifo_re(fifo_re),
    .fifo_clr(fifo_clr), .ch_timer_sel(ch_timer_sel), .ch_full_vol(ch_full_vol),
    .ch_en_l(ch_en_l), .ch_en_r(ch_en_r), .ch_reset(ch_reset),
    .psg_l(psg_l), .psg_r(psg_r), .psg_vol(psg_vol), .sample_tick(sample_tick),
    .sound_req(sound_req), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .overrun(overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Environment FIFOs and the reference model state.
  logic [31:0] fq   [NUM_CH][$];
  logic [7:0]  pend [NUM_CH][$];
  int          m_cur [NUM_CH];
  int          m_sel [NUM_CH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo_ports();
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_size[c*FIFO_LVL_W +: FIFO_LVL_W] = FIFO_LVL_W'(fq[c].size());
      fifo_val[c*32 +: 32] = (fq[c].size() > 0) ? fq[c][0] : 32'hDEADBEEF;
      ch_timer_sel[c*TSEL_W +: TSEL_W] = TSEL_W'(m_sel[c]);
    end
  endtask

  task automatic push_word(input int c, input logic [31:0] w);
    fq[c].push_back(w);
    drive_fifo_ports();
  endtask

  // One clock: the environment FIFOs react to the strobes seen before the edge.
  task automatic cyc();
    logic [NUM_CH-1:0] re, clr;
    re  = fifo_re;
    clr = fifo_clr;
    @(posedge clock);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (clr[c]) fq[c].delete();
      else if (re[c] && fq[c].size() > 0) void'(fq[c].pop_front());
    end
    timer_ovf   = '0;
    ch_reset    = '0;
    sample_tick = 1'b0;
    drive_fifo_ports();
  endtask

  function automatic int floor_div(input int a, input int d);
    int q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int sat(input int a);
    int hi, lo;
    hi = (1 << (OUT_W - 1)) - 1;
    lo = -(1 << (OUT_W - 1));
    return (a > hi) ? hi : ((a < lo) ? lo : a);
  endfunction

  // Sample-level channel model: a word yields four LSB-first samples.
  task automatic model_tick(input logic [NUM_TIMERS-1:0] ovf, input logic [NUM_CH-1:0] rst,
                            output logic [NUM_CH-1:0] exp_re, output logic [NUM_CH-1:0] exp_req);
    logic [31:0] w;
    logic [7:0]  b;
    exp_re  = '0;
    exp_req = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rst[c]) begin
        m_cur[c] = 0;
        pend[c].delete();
      end else if (ovf[m_sel[c]]) begin
        if (pend[c].size() > 0) begin
          b = pend[c].pop_front();
          m_cur[c] = int'($signed(b));
        end else if (fq[c].size() > 0) begin
          w = fq[c][0];
          exp_re[c] = 1'b1;
          m_cur[c] = int'($signed(w[7:0]));
          for (int k = 1; k < 4; k++) pend[c].push_back(w[8*k +: 8]);
          exp_req[c] = (fq[c].size() - 1) <= REQ_LEVEL;
        end else begin
          exp_req[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick_step(input string tag, input logic [NUM_TIMERS-1:0] ovf,
                           input logic [NUM_CH-1:0] rst);
    logic [NUM_CH-1:0] exp_re, exp_req;
    timer_ovf = ovf;
    ch_reset  = rst;
    #1;
    model_tick(ovf, rst, exp_re, exp_req);
    check({tag, "/fifo_re"}, 64'(fifo_re), 64'(exp_re));
    check({tag, "/fifo_clr"}, 64'(fifo_clr), 64'(rst));
    cyc();
    check({tag, "/sound_req"}, 64'(sound_req), 64'(exp_req));
  endtask

  // Issue sample_tick (optionally with timer ticks in the same cycle) and
  // compare the produced stereo sample, its latency and its pulse width.
  task automatic mix_check(input string tag, input logic [NUM_TIMERS-1:0] ovf);
    logic [NUM_CH-1:0]       exp_re, exp_req;
    logic signed [OUT_W-1:0] el, er, gl, gr;
    int el_i, er_i, term, lat, nvalid, d;
    timer_ovf   = ovf;
    sample_tick = 1'b1;
    #1;
    model_tick(ovf, '0, exp_re, exp_req);
    check({tag, "/fifo_re"}, 64'(fifo_re), 64'(exp_re));
    d = (psg_vol >= 2) ? 1 : ((psg_vol == 1) ? 2 : 4);
    el_i = floor_div(int'(psg_l), d);
    er_i = floor_div(int'(psg_r), d);
    for (int c = 0; c < NUM_CH; c++) begin
      term = m_cur[c] * (ch_full_vol[c] ? 2 : 1);
      if (ch_en_l[c]) el_i += term;
      if (ch_en_r[c]) er_i += term;
    end
    el = OUT_W'(sat(el_i));
    er = OUT_W'(sat(er_i));
    cyc();
    check({tag, "/sound_req"}, 64'(sound_req), 64'(exp_req));
    lat = -1; nvalid = 0; gl = '0; gr = '0;
    for (int i = 1; i <= 12; i++) begin
      if (out_valid === 1'b1) begin
        nvalid++;
        if (lat < 0) begin lat = i; gl = out_l; gr = out_r; end
      end
      cyc();
    end
    check({tag, "/latency"}, 64'(lat), 64'(NUM_CH + 3));
    check({tag, "/valid_cnt"}, 64'(nvalid), 64'd1);
    check({tag, "/out_l"}, 64'(gl), 64'(el));
    check({tag, "/out_r"}, 64'(gr), 64'(er));
  endtask

  initial begin
    int nvalid;
    reset_n = 1'b0; timer_ovf = '0; ch_reset = '0; sample_tick = 1'b0;
    ch_full_vol = '0; ch_en_l = '0; ch_en_r = '0;
    psg_l = '0; psg_r = '0; psg_vol = '0;
    fifo_size = '0; fifo_val = '0; ch_timer_sel = '0;
    m_sel[0] = 0; m_sel[1] = 1;
    for (int c = 0; c < NUM_CH; c++) m_cur[c] = 0;
    push_word(0, 32'h04030201);
    for (int k = 0; k < 4; k++) push_word(0, $urandom);

    // Reset: strobes gated, registered outputs cleared.
    ch_reset = '1; timer_ovf = '1;
    #1;
    check("rst/fifo_re", 64'(fifo_re), 64'd0);
    check("rst/fifo_clr", 64'(fifo_clr), 64'd0);
    cyc(); cyc();
    check("rst/sound_req", 64'(sound_req), 64'd0);
    check("rst/out_valid", 64'(out_valid), 64'd0);
    check("rst/out_l", 64'(out_l), 64'd0);
    check("rst/out_r", 64'(out_r), 64'd0);
    check("rst/overrun", 64'(overrun), 64'd0);
    reset_n = 1'b1;
    check("rst/fifo_size", 64'(fifo_size[3:0]), 64'd5);

    // PSG only at 25%, channels zero after reset.
    ch_en_l = '1; ch_en_r = '1; ch_full_vol = '1;
    psg_l = 16'sh1234; psg_r = -16'sh0123; psg_vol = 2'd0;
    mix_check("psg_only", '0);
    check("psg_only/overrun", 64'(overrun), 64'd0);

    // Unpack one word over four ticks; observe each sample through the mixer.
    ch_en_l = 2'b01; ch_en_r = 2'b00; ch_full_vol = 2'b01;
    psg_l = '0; psg_r = '0; psg_vol = 2'd2;
    for (int k = 0; k < 4; k++) begin
      tick_step("unpack", 2'b01, '0);
      mix_check("unpack_mix", '0);
    end

    // Underrun on an empty FIFO: no pop, request raised, sample held.
    tick_step("underrun", 2'b10, '0);

    // ch_reset beats a same-cycle tick; then fresh words are popped.
    tick_step("chreset", 2'b01, 2'b01);
    check("chreset/fifo_emptied", 64'(fifo_size[3:0]), 64'd0);
    push_word(0, 32'h1111117F);
    push_word(1, 32'h00000080);
    tick_step("fresh_pop", 2'b11, '0);

    // Reference mix: 0x7F full L, 0x80 half L+R, PSG 0x100 at 50%.
    ch_en_l = 2'b11; ch_en_r = 2'b10; ch_full_vol = 2'b01;
    psg_l = 16'sh0100; psg_r = '0; psg_vol = 2'd1;
    mix_check("ref_mix", '0);

    // Saturation on both rails.
    ch_en_l = 2'b01; ch_en_r = 2'b10; ch_full_vol = 2'b11;
    psg_l = 16'sh7FFF; psg_r = 16'sh8000; psg_vol = 2'd2;
    mix_check("saturate", '0);

    // Timer tick in the same cycle as sample_tick: mixer sees the new sample.
    psg_l = 16'sh0010; psg_r = 16'sh0020; psg_vol = 2'd3;
    mix_check("tick_with_mix", 2'b01);

    // Back-to-back sample_tick: one output, sticky overrun.
    sample_tick = 1'b1; cyc();
    sample_tick = 1'b1; cyc();
    check("overrun/set", 64'(overrun), 64'd1);
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) nvalid++;
      cyc();
    end
    check("overrun/valid_cnt", 64'(nvalid), 64'd1);
    mix_check("after_overrun", '0);
    check("overrun/sticky", 64'(overrun), 64'd1);

    // Reset in the middle of a mix aborts it and clears the channels.
    sample_tick = 1'b1; cyc();
    cyc();
    reset_n = 1'b0; cyc();
    reset_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cur[c] = 0;
      pend[c].delete();
    end
    check("midreset/overrun", 64'(overrun), 64'd0);
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) nvalid++;
      cyc();
    end
    check("midreset/valid_cnt", 64'(nvalid), 64'd0);
    ch_en_l = '1; ch_en_r = '1; psg_l = '0; psg_r = '0;
    mix_check("midreset/mix", '0);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (fq[c].size() < 12) repeat ($urandom_range(0, 2)) fq[c].push_back($urandom);
        m_sel[c] = $urandom_range(0, NUM_TIMERS - 1);
      end
      drive_fifo_ports();
      repeat ($urandom_range(1, 3))
        tick_step("rand_tick", NUM_TIMERS'($urandom),
                  ($urandom_range(0, 9) == 0) ? NUM_CH'($urandom) : '0);
      ch_en_l = NUM_CH'($urandom); ch_en_r = NUM_CH'($urandom);
      ch_full_vol = NUM_CH'($urandom);
      psg_l = 16'($urandom); psg_r = 16'($urandom); psg_vol = 2'($urandom);
      mix_check("rand_mix", ($urandom_range(0, 3) == 0) ? NUM_TIMERS'($urandom) : '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
